// File: rtl/adc_pkg.sv
// Shared types and helpers for the serial ADC capture engine.
// Frame defaults match the board's 12-bit ADC in a 16-bit frame.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        QUIET
    } state_t;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_DATA_BITS  = 12;

    // Width of a counter that must hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_serial_reader_sclk_divider.sv
// Serial clock generator: toggles sclk every CLK_DIV clk cycles while enabled,
// parks sclk high and clears its count whenever disabled.
module sclk_divider
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic sclk,
    output logic rise
);

    localparam int DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap = enable && (div_cnt == DIV_LAST);
    // Asserted on the clk edge that drives sclk high, i.e. the ADC sample point.
    assign rise = wrap && !sclk;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_serial_reader.sv
// Serial ADC capture engine: drives cs_n/sclk, shifts in one MSB-first frame per
// start request and presents the low DATA_BITS with a one-cycle valid strobe.
module adc_serial_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int FRAME_BITS    = ADC_FRAME_BITS,
    parameter int DATA_BITS     = ADC_DATA_BITS,
    parameter int QUIET_PERIODS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sdata,
    output logic                 sclk,
    output logic                 cs_n,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BW           = cnt_width(FRAME_BITS + 1);
    localparam int QUIET_CYCLES = QUIET_PERIODS * 2 * CLK_DIV;
    localparam int QW           = cnt_width(QUIET_CYCLES);

    state_t                state;
    state_t                next_state;
    logic [BW-1:0]         bit_cnt;
    logic [QW-1:0]         quiet_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic                  shift_en;
    logic                  sclk_rise;
    logic                  frame_done;
    logic                  quiet_done;

    assign shift_en   = (state == SHIFT);
    assign frame_done = (state == SHIFT) && (bit_cnt == BW'(FRAME_BITS));
    assign quiet_done = (state == QUIET) && (quiet_cnt == QW'(QUIET_CYCLES - 1));

    sclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_divider (
        .clk    (clk),
        .rst    (rst),
        .enable (shift_en),
        .sclk   (sclk),
        .rise   (sclk_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cs_n       = 1'b1;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                cs_n = 1'b0;
                if (frame_done) begin
                    next_state = QUIET;
                end
            end
            QUIET: begin
                if (quiet_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // Counters and shifter are cleared in IDLE so every frame starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= frame_done;
            frame_err <= frame_done && (|shift[FRAME_BITS-1:DATA_BITS]);
            if (frame_done) begin
                data <= shift[DATA_BITS-1:0];
            end
            case (state)
                IDLE: begin
                    bit_cnt   <= '0;
                    quiet_cnt <= '0;
                    shift     <= '0;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift   <= {shift[FRAME_BITS-2:0], sdata};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                QUIET: begin
                    quiet_cnt <= quiet_cnt + 1'b1;
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Scoreboard bench for adc_serial_reader: a behavioural ADC feeds queued frames,
// a second instance with CLK_DIV=4 runs one frame in parallel.
module tb_adc_serial_reader;

    localparam int CD          = 2;
    localparam int FB          = 16;
    localparam int QP          = 2;
    localparam int VALID_OFS   = 2 * CD * FB + 1;
    localparam int PERIOD      = 2 * CD * (FB + QP) + 2;
    localparam int IDLE_REL    = 2 * CD * FB + 2 + 2 * CD * QP;
    localparam int CD4         = 4;
    localparam int VALID_REL4  = 2 * CD4 * FB + 2;

    typedef struct {
        logic [11:0] data;
        logic        err;
        int          p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start4;
    logic        sdata0, sdata4;
    logic        sclk0, sclk4, cs_n0, cs_n4;
    logic [11:0] data0, data4;
    logic        valid0, valid4, ferr0, ferr4, busy0, busy4;

    int   checks = 0;
    int   failures = 0;
    int   pcnt = 0;

    exp_t        exp_q[$];
    logic [15:0] word_q[$];
    exp_t        e0;
    logic [15:0] cur0;
    logic [15:0] word4 = 16'h07E5;
    int   idx0 = 15, idx4 = 15;
    logic prev_cs0 = 1'b1, prev_sclk0 = 1'b1, prev_cs4 = 1'b1, prev_sclk4 = 1'b1;
    int   vcnt0 = 0, vcnt4 = 0, falls0 = 0;
    int   rise_cnt0 = 0, rises_last = 0, hi_run = 0, hi_run_last = 0;
    int   low_run4 = 0;
    bit   low_checked4 = 0;
    int   s4 = 0;

    adc_serial_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start0),
        .sdata     (sdata0),
        .sclk      (sclk0),
        .cs_n      (cs_n0),
        .data      (data0),
        .valid     (valid0),
        .frame_err (ferr0),
        .busy      (busy0)
    );

    adc_serial_reader #(.CLK_DIV(CD4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .start     (start4),
        .sdata     (sdata4),
        .sclk      (sclk4),
        .cs_n      (cs_n4),
        .data      (data4),
        .valid     (valid4),
        .frame_err (ferr4),
        .busy      (busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcnt++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at posedge %0d", tag, actual, expected, pcnt);
        end
    endtask

    // Queues one ADC word; when a completed frame is expected, its valid lands
    // VALID_OFS edges after the start-sampling edge (the next posedge), plus extra.
    task automatic applyStimulus(input logic [15:0] word, input bit expect_done, input int extra);
        exp_t e;
        word_q.push_back(word);
        if (expect_done) begin
            e.data = word[11:0];
            e.err  = |word[15:12];
            e.p    = pcnt + 1 + VALID_OFS + extra;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulseStart(output int s);
        start0 = 1'b1;
        s = pcnt + 1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while (busy0 !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy0 !== 1'b0) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    // ADC model and scoreboard monitor for the default instance.
    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            vcnt0++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e0 = exp_q.pop_front();
                checkOutput("data", 32'(data0), 32'(e0.data));
                checkOutput("frame_err", 32'(ferr0), 32'(e0.err));
                checkOutput("valid_cycle", pcnt, e0.p);
            end
        end else if (ferr0 === 1'b1) begin
            checkOutput("err_without_valid", 32'd1, 32'd0);
        end
        if (prev_cs0 && cs_n0 === 1'b0) begin
            falls0++;
            rise_cnt0   = 0;
            hi_run_last = hi_run;
            cur0 = (word_q.size() > 0) ? word_q.pop_front() : 16'h0000;
            idx0 = 15;
        end
        if (!prev_cs0 && cs_n0 === 1'b1) rises_last = rise_cnt0;
        if (cs_n0 === 1'b1) hi_run++; else hi_run = 0;
        if (prev_sclk0 && sclk0 === 1'b0 && cs_n0 === 1'b0) begin
            sdata0 = cur0[idx0];
            if (idx0 > 0) idx0--;
        end
        if (!prev_sclk0 && sclk0 === 1'b1 && cs_n0 === 1'b0) rise_cnt0++;
        prev_cs0   = (cs_n0 !== 1'b0);
        prev_sclk0 = (sclk0 !== 1'b0);
    end

    // ADC model and monitor for the CLK_DIV=4 instance.
    always @(negedge clk) begin
        if (valid4 === 1'b1) begin
            vcnt4++;
            checkOutput("div4_valid_cycle", pcnt - s4 + 1, VALID_REL4);
            checkOutput("div4_data", 32'(data4), 32'h7E5);
            checkOutput("div4_frame_err", 32'(ferr4), 32'd0);
        end
        if (prev_cs4 && cs_n4 === 1'b0) idx4 = 15;
        if (prev_sclk4 && sclk4 === 1'b0 && cs_n4 === 1'b0) begin
            sdata4 = word4[idx4];
            if (idx4 > 0) idx4--;
        end
        if (sclk4 === 1'b0 && cs_n4 === 1'b0) low_run4++;
        if (!prev_sclk4 && sclk4 === 1'b1 && !low_checked4) begin
            checkOutput("div4_half_period", low_run4, CD4);
            low_checked4 = 1;
        end
        if (sclk4 === 1'b1) low_run4 = 0;
        prev_cs4   = (cs_n4 !== 1'b0);
        prev_sclk4 = (sclk4 !== 1'b0);
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        int vsnap, fsnap;
        rst    = 1'b1;
        start0 = 1'b0;
        start4 = 1'b0;
        sdata0 = 1'b0;
        sdata4 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_sclk", 32'(sclk0), 32'd1);
        checkOutput("reset_cs_n", 32'(cs_n0), 32'd1);
        checkOutput("reset_data", 32'(data0), 32'd0);
        checkOutput("reset_valid", 32'(valid0), 32'd0);
        checkOutput("reset_frame_err", 32'(ferr0), 32'd0);
        checkOutput("reset_busy", 32'(busy0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single frame 0ABC (plus CLK_DIV=4 frame 07E5)");
        applyStimulus(16'h0ABC, 1, 0);
        start4 = 1'b1;
        s4 = pcnt + 1;
        pulseStart(s);
        start4 = 1'b0;
        checkOutput("busy_after_start", 32'(busy0), 32'd1);
        checkOutput("cs_n_after_start", 32'(cs_n0), 32'd0);
        waitIdle(200);
        checkOutput("idle_cycle", pcnt - s + 1, IDLE_REL);
        checkOutput("sclk_rises_per_frame", rises_last, FB);
        repeat (3) @(negedge clk);
        checkOutput("data_hold", 32'(data0), 32'hABC);

        $display("[TB] frame error 9FFF");
        applyStimulus(16'h9FFF, 1, 0);
        pulseStart(s);
        waitIdle(200);

        $display("[TB] back-to-back 001 800 555");
        applyStimulus(16'h0001, 1, 0);
        applyStimulus(16'h0800, 1, PERIOD);
        applyStimulus(16'h0555, 1, 2 * PERIOD);
        start0 = 1'b1;
        repeat (2 * PERIOD + 1) @(negedge clk);
        start0 = 1'b0;
        waitIdle(200);
        // The quiet window plus the one IDLE cycle in which start is sampled.
        checkOutput("cs_n_gap", hi_run_last, 2 * CD * QP + 1);

        $display("[TB] start while busy");
        vsnap = vcnt0;
        fsnap = falls0;
        applyStimulus(16'h0321, 1, 0);
        pulseStart(s);
        repeat (9) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (29) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        waitIdle(200);
        repeat (4) @(negedge clk);
        checkOutput("busy_start_valids", vcnt0 - vsnap, 1);
        checkOutput("busy_start_cs_falls", falls0 - fsnap, 1);

        $display("[TB] reset mid-frame");
        applyStimulus(16'h0FFF, 0, 0);
        vsnap = vcnt0;
        pulseStart(s);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_cs_n", 32'(cs_n0), 32'd1);
        checkOutput("abort_sclk", 32'(sclk0), 32'd1);
        checkOutput("abort_busy", 32'(busy0), 32'd0);
        checkOutput("abort_valid", 32'(valid0), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("abort_no_valid", vcnt0 - vsnap, 0);
        rst    = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start0 = 1'b0;
        checkOutput("reset_beats_start", 32'(busy0), 32'd0);
        @(negedge clk);
        applyStimulus(16'h0123, 1, 0);
        pulseStart(s);
        waitIdle(200);
        repeat (4) @(negedge clk);

        checkOutput("div4_valid_count", vcnt4, 1);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
